// File: rtl/filtro_imagen.sv
// filtro_imagen: frame-walking pixel filter feeding the VGA frame buffer.
// Reads every source pixel in raster order, applies pass/invert/threshold
// (or horizontal smoothing) and writes the result to the same address.
// Optional feature macro: FILTRO_SMOOTH_EN enables the smoothing filter
// (mode 3) together with its prev register and column counter; without it
// mode 3 behaves as pass.
module filtro_imagen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        filter_sel,
    input  logic [7:0]        param,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [7:0]        src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [7:0]        dst_data,
    output logic              dst_we,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [7:0]        r_param;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [ADDR_W-1:0] r_src_addr;
    logic [ADDR_W-1:0] r_dst_addr;
    logic [7:0]        r_dst_data;
    logic              r_dst_we;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        w_filt;

`ifdef FILTRO_SMOOTH_EN
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [XW-1:0] LP_XLAST = XW'(WIDTH - 1);

    logic [XW-1:0] r_x;
    logic [7:0]    r_cur;
    logic [7:0]    r_prev;
    logic [7:0]    w_p;
    logic [8:0]    w_sum;
`endif

    assign src_addr = r_src_addr;
    assign dst_addr = r_dst_addr;
    assign dst_data = r_dst_data;
    assign dst_we   = r_dst_we;
    assign busy     = r_busy;
    assign done     = r_done;

    // Filter applied to the pixel arriving from the source RAM during CAPTURE.
    always_comb begin
        w_filt = src_data;
`ifdef FILTRO_SMOOTH_EN
        w_p    = (r_x == '0) ? src_data : r_prev;
        w_sum  = {1'b0, w_p} + {1'b0, src_data} + 9'd1;
`endif
        case (r_mode)
            2'd1:    w_filt = 8'd255 - src_data;
            2'd2:    w_filt = (src_data >= r_param) ? '1 : '0;
`ifdef FILTRO_SMOOTH_EN
            2'd3:    w_filt = w_sum[8:1];
`endif
            default: w_filt = src_data;
        endcase
    end

    // Frame FSM with registered outputs. The read address is loaded on the
    // edge entering READ so it is already on src_addr throughout READ; the
    // write strobe and data are loaded on the edge entering WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mode     <= '0;
            r_param    <= '0;
            r_pix_addr <= '0;
            r_src_addr <= '0;
            r_dst_addr <= '0;
            r_dst_data <= '0;
            r_dst_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef FILTRO_SMOOTH_EN
            r_x        <= '0;
            r_cur      <= '0;
            r_prev     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done   <= 1'b0;
                    r_dst_we <= 1'b0;
                    if (start) begin
                        r_mode     <= filter_sel;
                        r_param    <= param;
                        r_pix_addr <= '0;
                        r_src_addr <= '0;
                        r_busy     <= 1'b1;
`ifdef FILTRO_SMOOTH_EN
                        r_x        <= '0;
`endif
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
`ifdef FILTRO_SMOOTH_EN
                    r_cur      <= src_data;
`endif
                    r_dst_we   <= 1'b1;
                    r_dst_addr <= r_pix_addr;
                    r_dst_data <= w_filt;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    r_dst_we <= 1'b0;
`ifdef FILTRO_SMOOTH_EN
                    r_prev   <= r_cur;
`endif
                    if (r_pix_addr == LP_LAST) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_pix_addr <= r_pix_addr + ADDR_W'(1);
                        r_src_addr <= r_pix_addr + ADDR_W'(1);
`ifdef FILTRO_SMOOTH_EN
                        r_x        <= (r_x == LP_XLAST) ? '0 : r_x + XW'(1);
`endif
                        r_state    <= S_READ;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
